// File: rtl/kl_pipe_pkg.sv
// Shared pipeline definitions: control-word layout, memory opcodes and the
// memory-access stage FSM state type.
package kl_pipe_pkg;

  localparam int unsigned CTRL_W = 22;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_LDR = 3'b011;
  localparam logic [OP_W-1:0] OP_STR = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memacc_state_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for the memory-access stage, with a
// terminal-count flag at WAIT_MAX.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic clear,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load 1 on entry to WAIT, count while waiting, never pass WAIT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    tc_c  = (cnt_q == CNT_W'(WAIT_MAX));
    if (clear) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(1);
    end else if (run && !tc_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_3_memaccess.sv
// Memory-access pipeline stage: issues LDR/STR to a sync RAM, stalls upstream
// while the RAM is not ready, and abandons an access after WAIT_MAX cycles.
module pipeline_3_memaccess
  import kl_pipe_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] storedata_in,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              stall_out,
  output logic              bus_error
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  memacc_state_t     state_q, state_d;
  logic              berr_q, berr_d;

  logic [OP_W-1:0] op;
  logic            is_ldr;
  logic            is_str;
  logic            mem_op;
  logic            abort;
  logic            complete;
  logic            tmr_start;
  logic            tmr_run;
  logic            tmr_clear;
  logic            tmr_tc_c;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .start (tmr_start),
    .run   (tmr_run),
    .clear (tmr_clear),
    .tc_c  (tmr_tc_c)
  );

  // Strobes, completion, stall and next state all derive from the held op.
  always_comb begin
    op        = ctrl_q[CTRL_W-1 -: OP_W];
    is_ldr    = (op == OP_LDR);
    is_str    = (op == OP_STR);
    mem_op    = is_mem_op(op);
    abort     = (state_q == ST_WAIT) && tmr_tc_c && !mem_ready;

    mem_read  = is_ldr && !abort;
    mem_write = is_str && !abort;
    mem_addr  = result_q;
    mem_wdata = sdata_q;

    complete  = mem_op ? ((mem_read || mem_write) && mem_ready) : 1'b1;
    stall_out = mem_op && !complete && !abort;

    control_out = complete ? ctrl_q : '0;
    result_out  = result_q;
    bus_error   = berr_q;

    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_run   = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_op && !mem_ready) begin
          state_d   = ST_WAIT;
          tmr_start = 1'b1;
        end
      end
      ST_WAIT: begin
        if (complete || abort) begin
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end else begin
          tmr_run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    berr_d   = berr_q | abort;
    ctrl_d   = stall_out ? ctrl_q   : control_in;
    result_d = stall_out ? result_q : result_in;
    sdata_d  = stall_out ? sdata_q  : storedata_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      result_q <= '0;
      sdata_q  <= '0;
      state_q  <= ST_IDLE;
      berr_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      state_q  <= state_d;
      berr_q   <= berr_d;
    end
  end

endmodule

// File: tb/tb_pipeline_3_memaccess.sv
// Self-checking bench for pipeline_3_memaccess: directed scenarios with literal
// expectations, then randomized traffic against an instruction-age model.
module tb_pipeline_3_memaccess;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] control_in;
  logic [15:0] result_in;
  logic [15:0] storedata_in;
  logic        mem_ready;
  logic [21:0] control_out;
  logic [15:0] result_out;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        stall_out;
  logic        bus_error;

  always #5 clk = ~clk;

  pipeline_3_memaccess #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .control_in   (control_in),
    .result_in    (result_in),
    .storedata_in (storedata_in),
    .mem_ready    (mem_ready),
    .control_out  (control_out),
    .result_out   (result_out),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .stall_out    (stall_out),
    .bus_error    (bus_error)
  );

  // Model: the instruction currently held, how many cycles it has been held,
  // and whether any access has ever been abandoned since reset.
  logic [21:0] m_ctrl;
  logic [15:0] m_res;
  logic [15:0] m_sd;
  int          m_age;
  bit          m_berr;
  bit          e_stall;
  bit          en_chk;

  logic [21:0] s_ctrl;
  logic [15:0] s_res, s_addr, s_wdata;
  logic        s_read, s_write, s_stall, s_berr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] mk(input logic [2:0] op, input logic we, input logic [2:0] rd);
    return {op, 15'h0, we, rd};
  endfunction

  // One clock: drive inputs, compare against the model mid-cycle, advance model.
  task automatic cycle(input logic [21:0] c, input logic [15:0] r, input logic [15:0] s,
                       input logic rdy, input logic rs);
    logic [2:0]  op;
    bit          memop, done, ab;
    logic [21:0] e_ctrl;
    bit          e_read, e_write;
    @(negedge clk);
    control_in   = c;
    result_in    = r;
    storedata_in = s;
    mem_ready    = rdy;
    rst          = rs;
    #1;
    op    = m_ctrl[21:19];
    memop = (op == 3'b011) || (op == 3'b100);
    done  = memop ? rdy : 1'b1;
    ab    = memop && !rdy && (m_age == WAIT_MAX);
    e_read  = (op == 3'b011) && !ab;
    e_write = (op == 3'b100) && !ab;
    e_ctrl  = done ? m_ctrl : 22'h0;
    e_stall = memop && !done && !ab;
    s_ctrl = control_out; s_res = result_out; s_addr = mem_addr; s_wdata = mem_wdata;
    s_read = mem_read; s_write = mem_write; s_stall = stall_out; s_berr = bus_error;
    if (en_chk) begin
      chk("control_out", 32'(s_ctrl), 32'(e_ctrl));
      chk("result_out", 32'(s_res), 32'(m_res));
      chk("mem_addr", 32'(s_addr), 32'(m_res));
      chk("mem_wdata", 32'(s_wdata), 32'(m_sd));
      chk("mem_read", 32'(s_read), 32'(e_read));
      chk("mem_write", 32'(s_write), 32'(e_write));
      chk("stall_out", 32'(s_stall), 32'(e_stall));
      chk("bus_error", 32'(s_berr), 32'(m_berr));
    end
    @(posedge clk);
    if (rs) begin
      m_ctrl = '0; m_res = '0; m_sd = '0; m_age = 0; m_berr = 1'b0;
      en_chk = 1'b1;
    end else begin
      if (ab) m_berr = 1'b1;
      if (!e_stall) begin
        m_ctrl = c; m_res = r; m_sd = s; m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    logic [21:0] ldr, ldr2, ldr3, str, cur_c;
    logic [15:0] cur_r, cur_s;
    bit          have;
    int          nstall, p, sel;
    logic [2:0]  rop;
    ldr  = mk(3'b011, 1'b1, 3'd3);
    ldr2 = mk(3'b011, 1'b1, 3'd6);
    ldr3 = mk(3'b011, 1'b1, 3'd1);
    str  = mk(3'b100, 1'b0, 3'd0);
    en_chk = 1'b0;
    m_ctrl = '0; m_res = '0; m_sd = '0; m_age = 0; m_berr = 1'b0;
    rst = 1'b1; control_in = '0; result_in = '0; storedata_in = '0; mem_ready = 1'b0;

    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_ctrl", 32'(s_ctrl), 32'h0);
    chk("rst_res", 32'(s_res), 32'h0);
    chk("rst_strobes", {30'h0, s_read, s_write}, 32'h0);
    chk("rst_stall", 32'(s_stall), 32'h0);
    chk("rst_berr", 32'(s_berr), 32'h0);

    // ALU op passes through the next cycle
    cycle(22'h00000B, 16'h1234, 16'h0, 1'b0, 1'b0);
    cycle(ldr, 16'h0040, 16'h0, 1'b1, 1'b0);
    chk("alu_ctrl", 32'(s_ctrl), 32'h00000B);
    chk("alu_res", 32'(s_res), 32'h1234);
    chk("alu_strobes", {30'h0, s_read, s_write}, 32'h0);
    chk("alu_stall", 32'(s_stall), 32'h0);

    // LDR accepted immediately
    cycle(str, 16'h0100, 16'hBEEF, 1'b1, 1'b0);
    chk("ldr_read", 32'(s_read), 32'h1);
    chk("ldr_addr", 32'(s_addr), 32'h0040);
    chk("ldr_ctrl", 32'(s_ctrl), 32'(22'h18000B));
    chk("ldr_stall", 32'(s_stall), 32'h0);

    // STR with three not-ready cycles
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(str, 16'h0100, 16'hBEEF, 1'b0, 1'b0);
      if (s_stall === 1'b1) nstall++;
      chk("str_write", 32'(s_write), 32'h1);
      chk("str_wdata", 32'(s_wdata), 32'hBEEF);
      chk("str_bubble", 32'(s_ctrl), 32'h0);
    end
    cycle(ldr2, 16'h0200, 16'h0, 1'b1, 1'b0);
    chk("str_done_stall", 32'(s_stall), 32'h0);
    chk("str_done_ctrl", 32'(s_ctrl), 32'(22'h200000));
    chk("str_stall_cycles", 32'(nstall), 32'd3);

    // LDR never accepted: abandoned at WAIT_MAX
    nstall = 0;
    for (int k = 0; k <= WAIT_MAX; k++) begin
      if (k < WAIT_MAX) cycle(ldr2, 16'h0200, 16'h0, 1'b0, 1'b0);
      else              cycle(22'h000005, 16'h5555, 16'h0, 1'b0, 1'b0);
      if (s_stall === 1'b1) nstall++;
    end
    chk("to_read", 32'(s_read), 32'h0);
    chk("to_stall", 32'(s_stall), 32'h0);
    chk("to_bubble", 32'(s_ctrl), 32'h0);
    chk("to_stall_cycles", 32'(nstall), 32'd15);
    cycle(22'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("to_berr", 32'(s_berr), 32'h1);
    chk("to_next_ctrl", 32'(s_ctrl), 32'h000005);
    chk("to_next_res", 32'(s_res), 32'h5555);
    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("berr_sticky", 32'(s_berr), 32'h1);

    // Ready arrives in the final WAIT cycle: completes without error
    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k <= WAIT_MAX; k++) begin
      if (k < WAIT_MAX) cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b0);
      else              cycle(22'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("late_read", 32'(s_read), 32'h1);
    chk("late_ctrl", 32'(s_ctrl), 32'(22'h180009));
    chk("late_stall", 32'(s_stall), 32'h0);
    cycle(22'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("late_berr", 32'(s_berr), 32'h0);

    // Reset in the second WAIT cycle
    cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b0);
    cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b0);
    cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b0);
    cycle(ldr3, 16'h0300, 16'h0, 1'b0, 1'b1);
    cycle(ldr3, 16'h0300, 16'h0, 1'b1, 1'b0);
    chk("rw_strobes", {30'h0, s_read, s_write}, 32'h0);
    chk("rw_ctrl", 32'(s_ctrl), 32'h0);
    chk("rw_stall", 32'(s_stall), 32'h0);
    chk("rw_berr", 32'(s_berr), 32'h0);
    cycle(22'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("rw_reissue", 32'(s_read), 32'h1);

    // Randomized traffic; upstream holds its instruction while stalled
    have = 1'b0; p = 50; cur_c = '0; cur_r = '0; cur_s = '0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        sel = int'($urandom_range(0, 2));
        p = (sel == 0) ? 5 : (sel == 1) ? 50 : 90;
      end
      if (!have) begin
        sel = int'($urandom_range(0, 9));
        rop = (sel < 3) ? 3'b011 : (sel < 6) ? 3'b100 : 3'($urandom_range(0, 7));
        cur_c = {rop, 19'($urandom)};
        cur_r = 16'($urandom);
        cur_s = 16'($urandom);
        have = 1'b1;
      end
      cycle(cur_c, cur_r, cur_s, 1'($urandom_range(0, 99) < 32'(p)),
            1'($urandom_range(0, 599) == 0));
      if (!e_stall && rst == 1'b0) have = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_3_memaccess.md
PIPELINE_3_MEMACCESS -- requirements
Module: pipeline_3_memaccess

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk`, `rst`.
REQ-002 SHALL declare parameter `WAIT_MAX`, default 15: maximum number of WAIT cycles before an access is abandoned.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `control_in` in 22: control word from execute; opcode in [21:19], write enable in [3], write register number in [2:0].
- `result_in` in 16: ALU result; this is the memory address for LDR/STR.
- `storedata_in` in 16: store data for STR.
- `mem_ready` in 1: memory handshake; high means the current access is accepted this cycle.
- `control_out` out 22: control word to the writeback stage.
- `result_out` out 16: result to the writeback stage.
- `mem_addr` out 16: sync-RAM address.
- `mem_wdata` out 16: sync-RAM write data.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `stall_out` out 1: high means upstream must hold its outputs.
- `bus_error` out 1: sticky timeout flag.

Function
REQ-004 Stage registers SHALL hold control, result and storedata; they SHALL load from the inputs on a rising edge when `stall_out` is 0, and hold otherwise.
REQ-005 Opcode 3'b011 is LDR and 3'b100 is STR; these are memory ops, and every other opcode is a non-memory op.
REQ-006 FSM states SHALL be IDLE and WAIT; a held memory op in IDLE is issued that same cycle.
REQ-007 `mem_read` SHALL equal (held op is LDR) AND no abort this cycle, and `mem_write` SHALL equal (held op is STR) AND no abort this cycle; both are combinational from the stage registers and the state.
REQ-008 `mem_addr` SHALL equal the held result and `mem_wdata` SHALL equal the held storedata, both combinational.
REQ-009 Completion: a memory op completes in the cycle `mem_ready` is 1 while the strobe is asserted, and a non-memory op completes in the cycle it is held.
REQ-010 `control_out` SHALL equal the held control in a completion cycle, and 22'b0 (bubble) otherwise; `result_out` SHALL always equal the held result.
REQ-011 `control_out` and `result_out` SHALL be combinational and unregistered, because the writeback stage registers them.
- Rationale: the read data for an LDR then arrives from the sync RAM one cycle later, aligned with the registered control.
REQ-012 In IDLE with a memory op held and `mem_ready` 0, the FSM SHALL go to WAIT, set the wait counter to 1, and assert `stall_out`.
REQ-013 In WAIT, `stall_out` SHALL be 1 and the counter SHALL increment each cycle; `mem_ready`=1 SHALL complete the op, return the FSM to IDLE, and drop `stall_out` in that same cycle.
REQ-014 Timeout: when the counter equals `WAIT_MAX` and `mem_ready` is 0 in that cycle, the stage SHALL:
- abort the access, deasserting both strobes in that cycle;
- output a bubble;
- set `bus_error`;
- return to IDLE with `stall_out` 0, so the next instruction loads.
REQ-015 Simultaneous: `mem_ready`=1 in the `WAIT_MAX` cycle SHALL count as completion, with no error.
REQ-016 `stall_out` SHALL equal (memory op held) AND NOT completion AND NOT abort.
REQ-017 The wait counter SHALL be `$clog2(WAIT_MAX+1)` bits wide and SHALL never wrap.
REQ-018 `bus_error` SHALL be sticky until `rst`.

Reset
REQ-019 `rst` SHALL clear all state: control register 0, result and storedata registers 0, FSM to IDLE, counter 0, `bus_error` 0.
REQ-020 With the registers cleared, the outputs after reset SHALL be: `control_out`=0, `result_out`=0, both strobes 0, `stall_out`=0.
REQ-021 `rst` asserted during WAIT SHALL abandon the access, leaving no pending strobe on the next cycle; `rst` SHALL take priority over every load and completion.

Structure
REQ-022 The shared package `kl_pipe_pkg` SHALL hold:
- `CTRL_W`=22;
- `OP_LDR`=3'b011;
- `OP_STR`=3'b100;
- FSM state typedef `memacc_state_t`.
REQ-023 The wait counter with its terminal-count compare SHALL be one sub-module, `mem_wait_timer`; the stage registers SHALL use the existing DFF library cells.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ALU op control=22'h00000B, result=16'h1234 -> next cycle `control_out`=22'h00000B, `result_out`=16'h1234, no strobes, no stall.
- LDR at addr 16'h0040 with `mem_ready`=1 immediately -> `mem_read`=1 and `mem_addr`=16'h0040 for one cycle; control passes through; `stall_out` never 1.
- STR data 16'hBEEF to 16'h0100, `mem_ready` low for 3 cycles -> `stall_out` high for exactly 3 cycles; `mem_write`/`mem_wdata` stable throughout; bubbles on `control_out`; control passes on the 4th cycle.
- LDR with `mem_ready` never asserted -> abort at counter 15; `bus_error`=1 and stays 1; the next instruction loads the following cycle.
- LDR with `mem_ready` first asserted in the 15th WAIT cycle -> completes; `bus_error` stays 0.
- `rst` in the 2nd WAIT cycle -> next cycle strobes 0, `control_out`=0, FSM in IDLE, `bus_error`=0.
